// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit: FSM states, access sizes and
// fixed addresses, plus small decode helpers used by the unit and its aligner.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        SLEEP   = 2'd2,
        WAKE    = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [31:0] LED_ADDR = 32'h0000_2000;

    // Size code 3 is not a real size; it behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SZ_WORD : size;
    endfunction

    // Half accesses need an even address, word accesses a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [1:0] sz;
        sz = norm_size(size);
        return ((sz == SZ_HALF) && addr_lo[0]) ||
               ((sz == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane logic: byte enables and lane replication for the
// outgoing request, and lane selection plus extension for returning load data.
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_addr_lo,
    input  logic [31:0] req_wdata,
    output logic [3:0]  lane_mask,
    output logic [31:0] lane_wdata,
    input  logic [1:0]  cap_size,
    input  logic [1:0]  cap_addr_lo,
    input  logic        cap_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [1:0]  req_sz;
    logic [1:0]  cap_sz;
    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Byte enables follow the low address bits; store data is replicated so
    // whichever lanes are enabled already carry the right bytes.
    always_comb begin
        req_sz     = norm_size(req_size);
        lane_mask  = 4'b0000;
        lane_wdata = 32'h0;
        case (req_sz)
            SZ_BYTE: begin
                lane_mask  = 4'b0001 << req_addr_lo;
                lane_wdata = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_mask  = req_addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                lane_mask  = 4'b1111;
                lane_wdata = req_wdata;
            end
        endcase
    end

    // Pick the addressed lane of the returned word and right-justify it,
    // zero- or sign-extending according to the captured request.
    always_comb begin
        cap_sz    = norm_size(cap_size);
        rd_shift  = rdata >> {cap_addr_lo, 3'b000};
        rd_byte   = rd_shift[7:0];
        rd_half   = cap_addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (cap_sz)
            SZ_BYTE: load_data = cap_unsigned ? {24'h0, rd_byte}
                                              : {{24{rd_byte[7]}}, rd_byte};
            SZ_HALF: load_data = cap_unsigned ? {16'h0, rd_half}
                                              : {{16{rd_half[15]}}, rd_half};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side load/store unit: single-cycle stores, one-stall-cycle loads,
// misalignment rejection and a sleep/wake handshake toward the data memory.
// Handshake: the CPU presents req_valid with a stable request; while stall=1
// it must hold that request unchanged, and the request is consumed in the
// first cycle it is presented with stall=0 (loads complete on rsp_valid).
module load_store_unit
    import mem_pkg::*;
#(
    parameter int WAKE_CYCLES = 1,
    parameter int ADDR_BITS   = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        wfi,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        misaligned,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    output logic [3:0]  mem_mask,
    output logic        mem_wfi,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] ADDR_MASK = (ADDR_BITS >= 32) ? 32'hFFFF_FFFF
                                        : ((32'd1 << ADDR_BITS) - 32'd1);
    localparam logic [3:0]  WAKE_LAST = 4'(WAKE_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic [3:0]  wake_cnt_q, wake_cnt_d;
    logic [1:0]  ld_size_q, ld_size_d;
    logic [1:0]  ld_lo_q, ld_lo_d;
    logic        ld_uns_q, ld_uns_d;
    logic        mem_wfi_q, mem_wfi_d;

    logic        req_mis;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    lsu_align u_align (
        .req_size     (req_size),
        .req_addr_lo  (req_addr[1:0]),
        .req_wdata    (req_wdata),
        .lane_mask    (lane_mask),
        .lane_wdata   (lane_wdata),
        .cap_size     (ld_size_q),
        .cap_addr_lo  (ld_lo_q),
        .cap_unsigned (ld_uns_q),
        .rdata        (mem_rdata),
        .load_data    (load_data)
    );

    // State register, wake counter, captured load attributes and mem_wfi flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wake_cnt_q <= 4'd0;
            ld_size_q  <= SZ_BYTE;
            ld_lo_q    <= 2'b00;
            ld_uns_q   <= 1'b0;
            mem_wfi_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            ld_size_q  <= ld_size_d;
            ld_lo_q    <= ld_lo_d;
            ld_uns_q   <= ld_uns_d;
            mem_wfi_q  <= mem_wfi_d;
        end
    end

    // Next-state and output decode; reset holds every output low.
    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        ld_size_d  = ld_size_q;
        ld_lo_d    = ld_lo_q;
        ld_uns_d   = ld_uns_q;
        stall      = 1'b0;
        rsp_valid  = 1'b0;
        rsp_data   = 32'h0;
        misaligned = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        mem_mask   = 4'b0000;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        req_mis    = is_misaligned(req_size, req_addr[1:0]);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_mis) begin
                        misaligned = 1'b1;
                    end else if (req_write) begin
                        mem_write = 1'b1;
                        mem_mask  = lane_mask;
                        mem_addr  = req_addr & ADDR_MASK;
                        mem_wdata = lane_wdata;
                    end else begin
                        mem_read  = 1'b1;
                        mem_mask  = lane_mask;
                        mem_addr  = req_addr & ADDR_MASK;
                        stall     = 1'b1;
                        ld_size_d = norm_size(req_size);
                        ld_lo_d   = req_addr[1:0];
                        ld_uns_d  = req_unsigned;
                        state_d   = RD_WAIT;
                    end
                end else if (wfi) begin
                    state_d = SLEEP;
                end
            end
            RD_WAIT: begin
                rsp_valid = 1'b1;
                rsp_data  = load_data;
                state_d   = IDLE;
            end
            SLEEP: begin
                stall = req_valid;
                if (!wfi) begin
                    state_d    = WAKE;
                    wake_cnt_d = 4'd0;
                end
            end
            WAKE: begin
                // wfi is deliberately not looked at here; sleep can only be
                // re-entered from IDLE.
                stall = req_valid;
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = IDLE;
                    wake_cnt_d = 4'd0;
                end else begin
                    wake_cnt_d = wake_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            stall      = 1'b0;
            rsp_valid  = 1'b0;
            rsp_data   = 32'h0;
            misaligned = 1'b0;
            mem_write  = 1'b0;
            mem_read   = 1'b0;
            mem_mask   = 4'b0000;
            mem_addr   = 32'h0;
            mem_wdata  = 32'h0;
        end

        mem_wfi_d = (state_d == SLEEP) && !rst;
    end

    assign mem_wfi = mem_wfi_q;

endmodule
